// File: rtl/swim_pkg.sv
// swim_pkg: shared SWIM receive FSM states, 48 MHz nominal timings and frame field widths
package swim_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;
  localparam int T_BIT      = 132;
  localparam int T_BIT1     = 12;
  localparam int T_BIT0     = 120;
  localparam int T_SYNC     = 768;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
endpackage

// File: rtl/swim_pulse_meas.sv
// swim_pulse_meas: line synchroniser, edge strobes and saturating low/high run counters
// Ports: clk, reset (sync, active-high), swim_in (async line level),
//        fall/rise (one-cycle strobes on synchronised line), low_width/high_width (run lengths)
module swim_pulse_meas #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swim_in,
  output logic             fall,
  output logic             rise,
  output logic [CNT_W-1:0] low_width,
  output logic [CNT_W-1:0] high_width
);
  logic s1, s, s_prev;
  assign fall = s_prev && !s;
  assign rise = !s_prev && s;
  // On the rise strobe low_width equals the number of clk the line was low.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s <= 1'b1;
      s_prev <= 1'b1;
      low_width <= '0;
      high_width <= '0;
    end else begin
      s1 <= swim_in;
      s <= s1;
      s_prev <= s;
      low_width <= fall ? CNT_W'(1) : (!s && !(&low_width)) ? low_width + 1'b1 : low_width;
      high_width <= rise ? '0 : (s && !(&high_width)) ? high_width + 1'b1 : high_width;
    end
  end
endmodule

// File: rtl/swim_rx.sv
// swim_rx: STM8 SWIM low-speed frame receiver with sync detect and valid/ready byte output
// Ports: clk, reset (sync, active-high), rx_en (decode enable), swim_in (async line),
//        rx_data/rx_header/rx_valid/rx_ready (byte handshake),
//        sync_det/parity_err/frame_err/overrun (one-cycle status pulses)
module swim_rx
  import swim_pkg::*;
#(
  parameter int BIT1_MAX     = 48,
  parameter int BIT0_MAX     = 300,
  parameter int SYNC_MIN     = 600,
  parameter int GLITCH_MIN   = 3,
  parameter int IDLE_TIMEOUT = 480,
  parameter int CNT_W        = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 swim_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_header,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 sync_det,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GLITCH_MIN);
  localparam logic [CNT_W-1:0] B1 = CNT_W'(BIT1_MAX);
  localparam logic [CNT_W-1:0] B0 = CNT_W'(BIT0_MAX);
  localparam logic [CNT_W-1:0] SY = CNT_W'(SYNC_MIN);
  localparam logic [CNT_W-1:0] T_OUT = CNT_W'(IDLE_TIMEOUT);
  localparam logic [3:0] LAST = 4'(FRAME_BITS - 1);
  state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic fall, rise;
  logic [CNT_W-1:0] w, hw;
  logic is_glitch, is_sync, is_long, is_bit;
  logic lrise, done, par_ok, good;
  logic ev_sync, ev_ferr, ev_perr, ev_ovr, ev_load;
  swim_pulse_meas #(.CNT_W(CNT_W)) u_meas (
    .clk(clk),
    .reset(reset),
    .swim_in(swim_in),
    .fall(fall),
    .rise(rise),
    .low_width(w),
    .high_width(hw)
  );
  assign is_glitch = w < G_MIN;
  assign is_sync = w >= SY;
  assign is_long = !is_sync && w > B0;
  assign is_bit = !is_glitch && !is_sync && !is_long;
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    if (!rx_en) begin
      state_n = S_IDLE;
      bit_cnt_n = '0;
    end else begin
      case (state)
        S_IDLE: state_n = fall ? S_LOW : S_IDLE;
        S_LOW: begin
          if (rise && is_glitch) state_n = (bit_cnt != 0) ? S_HIGH : S_IDLE;
          else if (rise && !is_bit) begin
            state_n = S_IDLE;
            bit_cnt_n = '0;
          end else if (rise) begin
            shreg_n = {shreg[FRAME_BITS-2:0], w <= B1};
            bit_cnt_n = (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
            state_n = (bit_cnt == LAST) ? S_IDLE : S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) state_n = S_LOW;
          else if (hw >= T_OUT) begin
            state_n = S_IDLE;
            bit_cnt_n = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
  // shreg_n already holds the final bit when the tenth bit completes the frame.
  always_comb begin
    lrise = rx_en && state == S_LOW && rise;
    done = lrise && is_bit && bit_cnt == LAST;
    par_ok = (^shreg_n[DATA_BITS:1]) == shreg_n[0];
    good = done && par_ok;
    ev_sync = lrise && is_sync;
    ev_ferr = (lrise && ((is_sync && bit_cnt != 0) || is_long)) ||
              (rx_en && state == S_HIGH && !fall && hw >= T_OUT);
    ev_perr = done && !par_ok;
    ev_load = good && (!rx_valid || rx_ready);
    ev_ovr = good && rx_valid && !rx_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_header <= 1'b0;
      rx_valid <= 1'b0;
      sync_det <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      sync_det <= ev_sync;
      parity_err <= ev_perr;
      frame_err <= ev_ferr;
      overrun <= ev_ovr;
      rx_valid <= ev_load || (rx_valid && !rx_ready);
      if (ev_load) begin
        rx_data <= shreg_n[DATA_BITS:1];
        rx_header <= shreg_n[FRAME_BITS-1];
      end
    end
  end
endmodule
